// File: rtl/fft_stage_ctrl.sv
// fft_stage_ctrl: pipeline sequencer for the 512-point radix-2 FFT front end.
// Counts 16-sample input beats into frames and pushes a {valid, block} tag
// down a fixed-latency model of module_00 -> twd_mul01 -> module_02. The
// enables, block indices and frame-done pulses the datapath consumes are
// taken from taps on that line. A counter limits the number of frames in flight.
//
// Optional feature macro: FFT_STAGE_CTRL_OVF_CHECK_EN
//   defined   : ovf_err latches when a beat is offered while din_ready is low
//   undefined : ovf_err is tied low and refused beats are ignored
//
// Input FSM:
//   state  | meaning
//   S_IDLE | no frame open, in_blk = 0; next accepted beat opens a frame
//   S_FILL | frame open, counting beats until BLK_PER_FRAME-1

module fft_stage_ctrl #(
  parameter int BLK_PER_FRAME = 32,
  parameter int LAT0          = 2,
  parameter int LAT1          = 4,
  parameter int LAT2          = 3,
  parameter int MAX_FRAMES    = 2,
  localparam int IW           = $clog2(BLK_PER_FRAME),
  localparam int FW           = $clog2(MAX_FRAMES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          din_valid,
  output logic          din_ready,
  output logic          stage0_valid,
  output logic [IW-1:0] stage0_blk,
  output logic          stage1_valid,
  output logic [IW-1:0] twd01_idx,
  output logic          stage2_valid,
  output logic [IW-1:0] stage2_blk,
  output logic          frame_done,
  output logic [FW-1:0] inflight,
  output logic          busy,
  output logic          ovf_err
);

  localparam int LT = LAT0 + LAT1 + LAT2;
  localparam int T0 = LAT0 - 1;
  localparam int T1 = LAT0 + LAT1 - 1;
  localparam int T2 = LT - 1;
  localparam logic [IW-1:0] LAST_BLK = IW'(BLK_PER_FRAME - 1);
  localparam logic [FW-1:0] MAX_INFL = FW'(MAX_FRAMES);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  state_t        state;
  logic [IW-1:0] in_blk;
  logic          accept;
  logic          open_frame;

  // line_v[k] holds the valid of the beat presented k+1 cycles ago; the
  // block index of the final stage lives directly in stage2_blk, so line_b
  // stops one entry short.
  logic [LT-1:0] line_v;
  logic [IW-1:0] line_b [LT-1];
  logic [LT-1:0] nxt_v;
  logic [IW-1:0] nxt_b  [LT];

  // Only a full frame count with no frame open refuses input; an open frame
  // always runs to completion. flush and rst also hold off input.
  assign din_ready    = !rst && !flush && !(state == S_IDLE && inflight == MAX_INFL);
  assign accept       = din_valid && din_ready;
  assign open_frame   = accept && (state == S_IDLE);
  assign busy         = (inflight != '0) || (state == S_FILL);

  assign stage0_valid = line_v[T0];
  assign stage1_valid = line_v[T1];
  assign stage2_valid = line_v[T2];
  assign twd01_idx    = stage0_blk;

  // Next value of every delay-line stage: the fresh tag enters at stage 0.
  always_comb begin
    nxt_v    = '0;
    nxt_v[0] = accept;
    nxt_b[0] = in_blk;
    for (int k = 1; k < LT; k++) begin
      nxt_v[k] = line_v[k-1];
      nxt_b[k] = line_b[k-1];
    end
  end

  // Input FSM, beat counter and frames-in-flight counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      in_blk   <= '0;
      inflight <= '0;
    end else if (flush) begin
      state    <= S_IDLE;
      in_blk   <= '0;
      inflight <= '0;
    end else begin
      if (accept) begin
        if (in_blk == LAST_BLK) begin
          in_blk <= '0;
          state  <= S_IDLE;
        end else begin
          in_blk <= in_blk + IW'(1);
          state  <= S_FILL;
        end
      end
      if (open_frame && !frame_done) begin
        inflight <= inflight + FW'(1);
      end else if (!open_frame && frame_done) begin
        inflight <= inflight - FW'(1);
      end
    end
  end

  // Valid half of the delay line; flush discards every beat in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_v <= '0;
    end else if (flush) begin
      line_v <= '0;
    end else begin
      line_v <= nxt_v;
    end
  end

  // Index half of the delay line; entries are only meaningful where valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LT - 1; k++) line_b[k] <= '0;
    end else begin
      for (int k = 0; k < LT - 1; k++) line_b[k] <= nxt_b[k];
    end
  end

  // Index outputs hold their last value while the matching valid is low;
  // frame_done rides with the last block of a frame at the stage 2 tap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage0_blk <= '0;
      stage2_blk <= '0;
      frame_done <= 1'b0;
    end else if (flush) begin
      frame_done <= 1'b0;
    end else begin
      if (nxt_v[T0]) stage0_blk <= nxt_b[T0];
      if (nxt_v[T2]) stage2_blk <= nxt_b[T2];
      frame_done <= nxt_v[T2] && (nxt_b[T2] == LAST_BLK);
    end
  end

`ifdef FFT_STAGE_CTRL_OVF_CHECK_EN
  // Sticky record of a beat offered while input was refused; only rst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_err <= 1'b0;
    end else if (din_valid && !din_ready) begin
      ovf_err <= 1'b1;
    end
  end
`else
  assign ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Testbench for fft_stage_ctrl. A scoreboard records every beat the bench
// presents (cycle and expected block index) and a negedge monitor pops it
// when each stage reports the beat. A second instance with a long module_02
// latency exercises the frames-in-flight limit and the overflow flag.

module tb_fft_stage_ctrl;

  localparam int BLK  = 32;
  localparam int IW   = 5;
  localparam int FW   = 2;
  localparam int L0   = 2;
  localparam int L1   = 4;
  localparam int L2   = 3;
  localparam int LT   = L0 + L1 + L2;
  localparam int B_L2 = 60;
  localparam int B_LT = L0 + L1 + B_L2;

`ifdef FFT_STAGE_CTRL_OVF_CHECK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct {
    int acc;
    int blk;
  } tag_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush, din_valid, din_ready;
  logic          stage0_valid, stage1_valid, stage2_valid, frame_done, busy, ovf_err;
  logic [IW-1:0] stage0_blk, twd01_idx, stage2_blk;
  logic [FW-1:0] inflight;

  logic          flush2, din_valid2, din_ready2;
  logic          stage0_valid2, stage1_valid2, stage2_valid2, frame_done2, busy2, ovf_err2;
  logic [IW-1:0] stage0_blk2, twd01_idx2, stage2_blk2;
  logic [FW-1:0] inflight2;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int m_blk       = 0;
  int fd_count    = 0;
  int last_fd_cyc = -1;
  logic [IW-1:0] last_s0 = '0;
  logic [IW-1:0] last_s2 = '0;
  tag_t q0[$];
  tag_t q1[$];
  tag_t q2[$];
  tag_t me;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_stage_ctrl #(
    .BLK_PER_FRAME(BLK), .LAT0(L0), .LAT1(L1), .LAT2(L2), .MAX_FRAMES(2)
  ) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .din_valid(din_valid), .din_ready(din_ready),
    .stage0_valid(stage0_valid), .stage0_blk(stage0_blk), .stage1_valid(stage1_valid),
    .twd01_idx(twd01_idx), .stage2_valid(stage2_valid), .stage2_blk(stage2_blk),
    .frame_done(frame_done), .inflight(inflight), .busy(busy), .ovf_err(ovf_err)
  );

  fft_stage_ctrl #(
    .BLK_PER_FRAME(BLK), .LAT0(L0), .LAT1(L1), .LAT2(B_L2), .MAX_FRAMES(2)
  ) u_bp (
    .clk(clk), .rst(rst), .flush(flush2), .din_valid(din_valid2), .din_ready(din_ready2),
    .stage0_valid(stage0_valid2), .stage0_blk(stage0_blk2), .stage1_valid(stage1_valid2),
    .twd01_idx(twd01_idx2), .stage2_valid(stage2_valid2), .stage2_blk(stage2_blk2),
    .frame_done(frame_done2), .inflight(inflight2), .busy(busy2), .ovf_err(ovf_err2)
  );

  // Scoreboard monitor for the main instance: pops each stage's expected beat.
  always @(negedge clk) begin
    if (!rst) begin
      if (stage0_valid) begin
        vectors++;
        if (q0.size() == 0) begin
          miscompares++;
          $display("FAIL stage0_spurious cyc=%0d got valid=1 want 0", cyc);
        end else begin
          me = q0.pop_front();
          if (cyc != me.acc + L0 || stage0_blk !== me.blk[IW-1:0] || twd01_idx !== me.blk[IW-1:0]) begin
            miscompares++;
            $display("FAIL stage0_beat cyc=%0d got blk=%0d twd=%0d want blk=%0d at cyc=%0d",
                     cyc, stage0_blk, twd01_idx, me.blk, me.acc + L0);
          end
          last_s0 = me.blk[IW-1:0];
        end
      end else begin
        if (q0.size() != 0 && q0[0].acc + L0 <= cyc) begin
          vectors++;
          miscompares++;
          $display("FAIL stage0_missing cyc=%0d got valid=0 want blk=%0d", cyc, q0[0].blk);
          void'(q0.pop_front());
        end
        vectors++;
        if (stage0_blk !== last_s0 || twd01_idx !== last_s0) begin
          miscompares++;
          $display("FAIL stage0_hold cyc=%0d got blk=%0d twd=%0d want %0d", cyc, stage0_blk, twd01_idx, last_s0);
        end
      end

      if (stage1_valid) begin
        vectors++;
        if (q1.size() == 0) begin
          miscompares++;
          $display("FAIL stage1_spurious cyc=%0d got valid=1 want 0", cyc);
        end else begin
          me = q1.pop_front();
          if (cyc != me.acc + L0 + L1) begin
            miscompares++;
            $display("FAIL stage1_timing got cyc=%0d want cyc=%0d", cyc, me.acc + L0 + L1);
          end
        end
      end else if (q1.size() != 0 && q1[0].acc + L0 + L1 <= cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL stage1_missing cyc=%0d got valid=0 want 1", cyc);
        void'(q1.pop_front());
      end

      if (stage2_valid) begin
        vectors++;
        if (q2.size() == 0) begin
          miscompares++;
          $display("FAIL stage2_spurious cyc=%0d got valid=1 want 0", cyc);
        end else begin
          me = q2.pop_front();
          if (cyc != me.acc + LT || stage2_blk !== me.blk[IW-1:0] ||
              frame_done !== (me.blk == BLK - 1)) begin
            miscompares++;
            $display("FAIL stage2_beat cyc=%0d got blk=%0d done=%0b want blk=%0d done=%0b at cyc=%0d",
                     cyc, stage2_blk, frame_done, me.blk, (me.blk == BLK - 1), me.acc + LT);
          end
          last_s2 = me.blk[IW-1:0];
        end
      end else begin
        if (q2.size() != 0 && q2[0].acc + LT <= cyc) begin
          vectors++;
          miscompares++;
          $display("FAIL stage2_missing cyc=%0d got valid=0 want blk=%0d", cyc, q2[0].blk);
          void'(q2.pop_front());
        end
        vectors++;
        if (stage2_blk !== last_s2 || frame_done !== 1'b0) begin
          miscompares++;
          $display("FAIL stage2_idle cyc=%0d got blk=%0d done=%0b want blk=%0d done=0",
                   cyc, stage2_blk, frame_done, last_s2);
        end
      end

      if (frame_done === 1'b1) begin
        fd_count++;
        last_fd_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_beat();
    tag_t t;
    t.acc = cyc;
    t.blk = m_blk;
    q0.push_back(t);
    q1.push_back(t);
    q2.push_back(t);
    m_blk = (m_blk + 1) % BLK;
  endtask

  task automatic clear_sb();
    q0.delete();
    q1.delete();
    q2.delete();
    m_blk = 0;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; din_valid = 1'b0; flush2 = 1'b0; din_valid2 = 1'b0;
    tick();
    tick();
    vectors++;
    if (din_ready !== 1'b0 || stage0_valid !== 1'b0 || stage2_valid !== 1'b0 || frame_done !== 1'b0 ||
        inflight !== '0 || busy !== 1'b0 || ovf_err !== 1'b0 || stage0_blk !== '0 || stage2_blk !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got rdy=%0b v0=%0b v2=%0b fd=%0b infl=%0d busy=%0b ovf=%0b want all 0",
               din_ready, stage0_valid, stage2_valid, frame_done, inflight, busy, ovf_err);
    end
    rst = 1'b0;
    clear_sb();
    last_s0 = '0;
    last_s2 = '0;
    #1;
    vectors++;
    if (din_ready !== 1'b1 || din_ready2 !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready got %0b/%0b want 1/1", din_ready, din_ready2);
    end
  endtask

  task automatic test_single_frame();
    int c0 = 0;
    int fd0 = fd_count;
    for (int k = 0; k < BLK; k++) begin
      tick();
      if (k == 0) c0 = cyc;
      if (k == 1) begin
        vectors++;
        if (inflight !== 2'd1 || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL single_open got inflight=%0d busy=%0b want 1/1", inflight, busy);
        end
      end
      vectors++;
      if (din_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL single_ready k=%0d got 0 want 1", k);
      end
      din_valid = 1'b1;
      push_beat();
    end
    tick();
    idle(LT + 2);
    vectors++;
    if (fd_count - fd0 != 1 || last_fd_cyc != c0 + BLK - 1 + LT) begin
      miscompares++;
      $display("FAIL single_done got count=%0d cyc=%0d want 1 at cyc=%0d",
               fd_count - fd0, last_fd_cyc, c0 + BLK - 1 + LT);
    end
    vectors++;
    if (inflight !== '0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_drain got inflight=%0d busy=%0b want 0/0", inflight, busy);
    end
  endtask

  task automatic test_gapped();
    int c0 = 0;
    int fd0 = fd_count;
    for (int k = 0; k < BLK; k++) begin
      tick();
      if (k == 0) c0 = cyc;
      din_valid = 1'b1;
      push_beat();
      tick();
      din_valid = 1'b0;
    end
    idle(LT + 3);
    vectors++;
    if (fd_count - fd0 != 1 || last_fd_cyc != c0 + 2 * (BLK - 1) + LT) begin
      miscompares++;
      $display("FAIL gapped_done got count=%0d cyc=%0d want 1 at cyc=%0d",
               fd_count - fd0, last_fd_cyc, c0 + 2 * (BLK - 1) + LT);
    end
  endtask

  task automatic test_back_to_back();
    int c0 = 0;
    int fd0 = fd_count;
    for (int k = 0; k < 3 * BLK; k++) begin
      tick();
      if (k == 0) c0 = cyc;
      vectors++;
      if (din_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_ready k=%0d got 0 want 1", k);
      end
      if (k == 35) begin
        vectors++;
        if (inflight !== 2'd2) begin
          miscompares++;
          $display("FAIL b2b_inflight2 got %0d want 2", inflight);
        end
      end
      if (k == 45) begin
        vectors++;
        if (inflight !== 2'd1) begin
          miscompares++;
          $display("FAIL b2b_inflight1 got %0d want 1", inflight);
        end
      end
      din_valid = 1'b1;
      push_beat();
    end
    tick();
    idle(LT + 3);
    vectors++;
    if (fd_count - fd0 != 3 || inflight !== '0) begin
      miscompares++;
      $display("FAIL b2b_drain got frames=%0d inflight=%0d want 3/0", fd_count - fd0, inflight);
    end
  endtask

  task automatic test_simultaneous();
    int fd0 = fd_count;
    for (int k = 0; k < 40 + BLK; k++) begin
      tick();
      if (k == 40) begin
        vectors++;
        if (frame_done !== 1'b1 || din_ready !== 1'b1 || inflight !== 2'd1) begin
          miscompares++;
          $display("FAIL simul_event got done=%0b rdy=%0b infl=%0d want 1/1/1", frame_done, din_ready, inflight);
        end
      end
      if (k == 41) begin
        vectors++;
        if (inflight !== 2'd1 || din_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL simul_after got infl=%0d rdy=%0b want 1/1", inflight, din_ready);
        end
      end
      din_valid = (k < BLK) || (k >= 40);
      if (din_valid) push_beat();
    end
    tick();
    idle(LT + 3);
    vectors++;
    if (fd_count - fd0 != 2 || inflight !== '0) begin
      miscompares++;
      $display("FAIL simul_drain got frames=%0d inflight=%0d want 2/0", fd_count - fd0, inflight);
    end
  endtask

  task automatic test_flush();
    int fd0;
    int bad = 0;
    for (int k = 0; k < BLK + 17; k++) begin
      tick();
      din_valid = 1'b1;
      push_beat();
    end
    tick();
    din_valid = 1'b0;
    flush = 1'b1;
    #1;
    vectors++;
    if (din_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_ready got 1 want 0");
    end
    clear_sb();
    fd0 = fd_count;
    tick();
    flush = 1'b0;
    vectors++;
    if (inflight !== '0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_state got inflight=%0d busy=%0b want 0/0", inflight, busy);
    end
    for (int k = 0; k < LT + 3; k++) begin
      tick();
      if (stage0_valid || stage1_valid || stage2_valid) bad++;
    end
    vectors++;
    if (bad != 0 || fd_count != fd0) begin
      miscompares++;
      $display("FAIL flush_discard got valid_cycles=%0d frames=%0d want 0/0", bad, fd_count - fd0);
    end
    for (int k = 0; k < BLK; k++) begin
      tick();
      din_valid = 1'b1;
      push_beat();
    end
    tick();
    idle(LT + 3);
    vectors++;
    if (fd_count - fd0 != 1 || inflight !== '0 || ovf_err !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_restart got frames=%0d inflight=%0d ovf=%0b want 1/0/0",
               fd_count - fd0, inflight, ovf_err);
    end
  endtask

  task automatic test_backpressure();
    bit exp_rdy;
    for (int k = 0; k <= 100; k++) begin
      tick();
      exp_rdy = !(k >= 64 && k <= 97);
      vectors++;
      if (din_ready2 !== exp_rdy) begin
        miscompares++;
        $display("FAIL bp_ready k=%0d got %0b want %0b", k, din_ready2, exp_rdy);
      end
      if (k == 35 || k == 97) begin
        vectors++;
        if (inflight2 !== 2'd2 || frame_done2 !== (k == 97)) begin
          miscompares++;
          $display("FAIL bp_full k=%0d got infl=%0d done=%0b want 2/%0b", k, inflight2, frame_done2, (k == 97));
        end
      end
      if (k == 98) begin
        vectors++;
        if (inflight2 !== 2'd1) begin
          miscompares++;
          $display("FAIL bp_release got inflight=%0d want 1", inflight2);
        end
      end
      if (k == 63 || k == 66) begin
        vectors++;
        if (ovf_err2 !== (k == 66 && OVF_EN)) begin
          miscompares++;
          $display("FAIL bp_ovf k=%0d got %0b want %0b", k, ovf_err2, (k == 66 && OVF_EN));
        end
      end
      din_valid2 = (k <= 99);
    end
  endtask

  task automatic test_ovf_flush();
    int bad = 0;
    tick();
    flush2 = 1'b1;
    #1;
    vectors++;
    if (din_ready2 !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_flush_ready got 1 want 0");
    end
    tick();
    flush2 = 1'b0;
    vectors++;
    if (inflight2 !== '0 || busy2 !== 1'b0 || ovf_err2 !== OVF_EN) begin
      miscompares++;
      $display("FAIL ovf_flush_state got infl=%0d busy=%0b ovf=%0b want 0/0/%0b",
               inflight2, busy2, ovf_err2, OVF_EN);
    end
    for (int k = 0; k < B_LT + 2; k++) begin
      tick();
      if (stage2_valid2 || frame_done2) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL ovf_flush_discard got %0d stage2 cycles want 0", bad);
    end
    rst = 1'b1;
    clear_sb();
    last_s0 = '0;
    last_s2 = '0;
    #1;
    vectors++;
    if (ovf_err2 !== 1'b0 || inflight2 !== '0) begin
      miscompares++;
      $display("FAIL rst_clear got ovf=%0b infl=%0d want 0/0", ovf_err2, inflight2);
    end
    tick();
    rst = 1'b0;
    tick();
    vectors++;
    if (din_ready !== 1'b1 || din_ready2 !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_ready got %0b/%0b want 1/1", din_ready, din_ready2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_gapped();
    test_back_to_back();
    test_simultaneous();
    test_flush();
    test_backpressure();
    test_ovf_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
